argmax_classifier: RTL



---
 rtl/nn_pkg.sv | 20 ++
 rtl/argmax_classifier.sv | 136 +++++++++++++
 2 files changed

// File: rtl/nn_pkg.sv
// Shared constants for the neural-network output stages.
// Holds the activation width default, state codes and a clog2 helper.
package nn_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_classifier.sv
// Buffers one activation per class, then scans one entry per cycle
// for the signed maximum and strobes the winning index and value.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int NEURON_NUM = 10,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NEURON_NUM*DATA_WIDTH-1:0] layer_output,
    input  logic [NEURON_NUM-1:0]          layer_output_valid,
    output logic [IDX_WIDTH-1:0]           max_index,
    output logic [DATA_WIDTH-1:0]          max_value,
    output logic                           result_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NEURON_NUM - 1);

    if (NEURON_NUM < 2 || clog2(NEURON_NUM) > IDX_WIDTH) begin : g_bad_params
        $error("argmax_classifier: bad NEURON_NUM/IDX_WIDTH");
    end

    logic [1:0]            state_q, state_d;
    logic [NEURON_NUM-1:0] got_q, got_d;
    logic [DATA_WIDTH-1:0] mem_q [NEURON_NUM];
    logic [DATA_WIDTH-1:0] mem_d [NEURON_NUM];
    logic [DATA_WIDTH-1:0] cur_max_q, cur_max_d;
    logic [IDX_WIDTH-1:0]  cur_idx_q, cur_idx_d;
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]  max_index_q, max_index_d;
    logic [DATA_WIDTH-1:0] max_value_q, max_value_d;
    logic                  result_valid_q, result_valid_d;
    logic                  overrun_q, overrun_d;

    logic [DATA_WIDTH-1:0] scan_val;
    logic [DATA_WIDTH-1:0] win_val;
    logic [IDX_WIDTH-1:0]  win_idx;

    // Strict greater-than keeps the lower index on a tie.
    always_comb begin
        scan_val = mem_q[ptr_q];
        win_val  = cur_max_q;
        win_idx  = cur_idx_q;
        if ($signed(scan_val) > $signed(cur_max_q)) begin
            win_val = scan_val;
            win_idx = ptr_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        got_d          = got_q;
        mem_d          = mem_q;
        cur_max_d      = cur_max_q;
        cur_idx_d      = cur_idx_q;
        ptr_d          = ptr_q;
        max_index_d    = max_index_q;
        max_value_d    = max_value_q;
        result_valid_d = 1'b0;
        overrun_d      = overrun_q;
        unique case (state_q)
            COLLECT: begin
                for (int i = 0; i < NEURON_NUM; i++) begin
                    if (layer_output_valid[i]) begin
                        mem_d[i] = layer_output[i*DATA_WIDTH +: DATA_WIDTH];
                        got_d[i] = 1'b1;
                    end
                end
                if (&got_q) begin
                    state_d   = SCAN;
                    cur_max_d = mem_q[0];
                    cur_idx_d = '0;
                    ptr_d     = IDX_WIDTH'(1);
                    got_d     = '0;
                end
            end
            SCAN: begin
                if (|layer_output_valid) overrun_d = 1'b1;
                cur_max_d = win_val;
                cur_idx_d = win_idx;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    max_value_d    = win_val;
                    max_index_d    = win_idx;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (|layer_output_valid) overrun_d = 1'b1;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= COLLECT;
            got_q          <= '0;
            cur_max_q      <= '0;
            cur_idx_q      <= '0;
            ptr_q          <= '0;
            max_index_q    <= '0;
            max_value_q    <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            got_q          <= got_d;
            cur_max_q      <= cur_max_d;
            cur_idx_q      <= cur_idx_d;
            ptr_q          <= ptr_d;
            max_index_q    <= max_index_d;
            max_value_q    <= max_value_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign max_index    = max_index_q;
    assign max_value    = max_value_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != COLLECT);
    assign overrun      = overrun_q;

endmodule
